// File: rtl/mem_copy_master_if.sv
// Memory bus shared by the CPU and the copy engine: one address, a two-bit
// command (10 read, 01 write), gated read data and registered write data.
interface mem_copy_master_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_cmd;
   logic [DATA_W-1:0] read_data;
   logic [DATA_W-1:0] write_data;

   modport master (
      output mem_addr, mem_cmd, write_data,
      input  read_data
   );

   modport slave (
      input  mem_addr, mem_cmd, write_data,
      output read_data
   );
endinterface

// File: rtl/mem_copy_master.sv
// Block copy engine: reads one word from the source range, writes it to the
// destination range, and repeats in ascending order until len words are moved.
// Every bus output is registered, so each state's bus values are loaded on the
// edge that enters that state.
module mem_copy_master #(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 16,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] len,
   mem_copy_master_if.master bus,
   output logic              busy,
   output logic              done
);
   localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FIN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] count;
   logic [LAT_W-1:0]  lat_cnt;
   logic [ADDR_W-1:0] next_count;

   // Pointer arithmetic wraps modulo 2^ADDR_W; no I/O decoding is done here.
   assign next_count = count + ONE;

   // Copy sequencer; bus outputs, busy and done are loaded alongside state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         src_q          <= '0;
         dst_q          <= '0;
         len_q          <= '0;
         count          <= '0;
         lat_cnt        <= '0;
         bus.mem_addr   <= '0;
         bus.mem_cmd    <= 2'b00;
         bus.write_data <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     src_q        <= src_addr;
                     dst_q        <= dst_addr;
                     len_q        <= len;
                     count        <= '0;
                     bus.mem_addr <= src_addr;
                     bus.mem_cmd  <= 2'b10;
                     busy         <= 1'b1;
                     state        <= RD;
                  end else begin
                     // Empty copy: report completion without touching the bus.
                     done  <= 1'b1;
                     state <= FIN;
                  end
               end
            end
            RD: begin
               // Read stays asserted through WAIT since read_data is gated by it.
               lat_cnt <= LAT_W'(READ_LAT - 1);
               state   <= WAIT;
            end
            WAIT: begin
               if (lat_cnt == '0) begin
                  bus.write_data <= bus.read_data;
                  bus.mem_addr   <= dst_q + count;
                  bus.mem_cmd    <= 2'b01;
                  state          <= WR;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            WR: begin
               count <= next_count;
               if (next_count == len_q) begin
                  bus.mem_cmd <= 2'b00;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= FIN;
               end else begin
                  bus.mem_addr <= src_q + next_count;
                  bus.mem_cmd  <= 2'b10;
                  state        <= RD;
               end
            end
            FIN: state <= IDLE;
            default: begin
               bus.mem_cmd <= 2'b00;
               busy        <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end
endmodule
